// File: rtl/reg_file_pkg.sv
// Shared constants for the 32 x 32-bit register file: address/data widths,
// entry count and the hard-wired zero register address.
package reg_file_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_decoder.sv
// decoder_5to32: write-port address decoder. Produces a one-hot select for
// the addressed entry when en is high, all zeros otherwise.
module decoder_5to32
  import reg_file_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] a,
  input  logic                  en,
  output logic [REG_COUNT-1:0]  y
);

  // One-hot decode of the address, gated by the enable.
  always_comb begin
    y = '0;
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32-entry, 32-bit register file with two combinational read ports
// and one write port. Storage updates on the falling edge of clk so that a
// single-cycle datapath writes back mid-cycle and the next instruction reads
// the new value without a hazard. Entry 0 has no storage and always reads 0.
//
// Optional build macro:
//   REG_FILE_BYPASS_EN - forward wd to a read port in the same cycle when that
//                        port reads the address being written (not during
//                        reset, never for entry 0).
module reg_file
  import reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [REG_DATA_W-1:0] wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  output logic [REG_DATA_W-1:0] rd1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [REG_DATA_W-1:0] rd2
);

  // Entries 1..31 only; entry 0 is a constant zero in the read muxes.
  logic [REG_DATA_W-1:0] r_regs [1:REG_COUNT-1];

  logic [REG_COUNT-1:0]  w_dec;
  logic [REG_COUNT-1:0]  w_en;
  logic [REG_DATA_W-1:0] w_din;
  logic [REG_DATA_W-1:0] w_rd1_stored;
  logic [REG_DATA_W-1:0] w_rd2_stored;
  // Decoder output for entry 0 is intentionally dropped: writes there vanish.
  logic                  w_unused_dec0;

  decoder_5to32 u_dec (
    .a  (wa),
    .en (we),
    .y  (w_dec)
  );

  assign w_unused_dec0 = w_dec[0];

  // Reset enables every entry and forces the data input to zero, so a write
  // presented alongside reset is lost.
  assign w_en  = reset ? '1 : w_dec;
  assign w_din = reset ? '0 : wd;

  // Falling-edge storage update for entries 1..31.
  always_ff @(negedge clk) begin
    for (int i = 1; i < REG_COUNT; i++) begin
      if (w_en[i]) begin
        r_regs[i] <= w_din;
      end
    end
  end

  // Read port 1 mux: entry 0 falls through to the zero default.
  always_comb begin
    w_rd1_stored = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (ra1 == REG_ADDR_W'(i)) begin
        w_rd1_stored = r_regs[i];
      end
    end
  end

  // Read port 2 mux: independent copy of port 1.
  always_comb begin
    w_rd2_stored = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (ra2 == REG_ADDR_W'(i)) begin
        w_rd2_stored = r_regs[i];
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic w_byp_ok;
  // A write is forwardable only when it will actually land in storage.
  assign w_byp_ok = we && !reset && (wa != REG_ZERO);

  // Same-cycle forwarding of the write data onto matching read ports.
  always_comb begin
    rd1 = w_rd1_stored;
    rd2 = w_rd2_stored;
    if (w_byp_ok && (ra1 == wa)) begin
      rd1 = wd;
    end
    if (w_byp_ok && (ra2 == wa)) begin
      rd2 = wd;
    end
  end
`else
  assign rd1 = w_rd1_stored;
  assign rd2 = w_rd2_stored;
`endif

endmodule
